regfile_sb: RTL and testbench

- Parametrised register file with a built-in write-pending scoreboard; next generation of the processor's 8x16 register bank.
- Adds configurable width, depth and read-port count, same-cycle write-to-read bypass, optional hardwired-zero R0, and per-register busy tracking for the issue stage's hazard checks.
- Sits between decode/issue (reads operands, marks destinations pending) and writeback (writes results, clears pending).

---
 rtl/regfile_sb_pkg.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 89 ++++++++
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared defaults, the count-update encoding and helper
// functions for the regfile_sb register file and its scoreboard.
package regfile_sb_pkg;

  localparam int RF_DEF_DATA_W   = 16;
  localparam int RF_DEF_NUM_REGS = 8;
  localparam int RF_DEF_NUM_RD   = 2;

  // Widest word the parity helper covers and widest busy vector popcount covers.
  localparam int RF_MAX_DATA_W   = 64;
  localparam int RF_MAX_REGS     = 64;

  // Pending-count update selected from {increment, decrement}.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

  function automatic int rf_addr_w(input int n);
    return $clog2(n);
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic rf_parity(input logic [RF_MAX_DATA_W-1:0] d);
    return ^d;
  endfunction

  // Number of set bits in a busy vector (zero-extended to RF_MAX_REGS).
  function automatic logic [7:0] rf_popcount(input logic [RF_MAX_REGS-1:0] v);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < RF_MAX_REGS; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register write-pending bits for the issue stage.
// Issue sets a bit, writeback clears it, a same-cycle issue to the same
// register wins. pend_cnt tracks the number of set bits one step at a time.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NUM_REGS = RF_DEF_NUM_REGS,
  parameter int R0_ZERO  = 1,
  localparam int ADDR_W  = rf_addr_w(NUM_REGS),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    pend_cnt
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] clr_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                iss_ok_s;
  logic                inc_s;
  logic                dec_s;
  cnt_op_e             cnt_op_s;

  // An issue to a hardwired-zero R0 is ignored so R0 can never become busy.
  always_comb begin
    if ((R0_ZERO != 0) && (iss_addr == {ADDR_W{1'b0}})) begin
      iss_ok_s = 1'b0;
    end else begin
      iss_ok_s = iss_en;
    end
  end

  // Per-register set/clear decode; a set takes priority over a clear.
  always_comb begin
    set_s      = {NUM_REGS{1'b0}};
    clr_s      = {NUM_REGS{1'b0}};
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_s[i] = iss_ok_s && (iss_addr == ADDR_W'(i));
      clr_s[i] = wr_en && (wr_addr == ADDR_W'(i));
      if (set_s[i]) begin
        busy_nxt_s[i] = 1'b1;
      end else if (clr_s[i]) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Count delta: +1 when a free register goes busy, -1 when a busy register
  // retires without being reissued in the same cycle.
  always_comb begin
    inc_s    = iss_ok_s && !busy_r[iss_addr];
    dec_s    = wr_en && busy_r[wr_addr] && !(iss_ok_s && (iss_addr == wr_addr));
    cnt_op_s = cnt_op_e'({inc_s, dec_s});
    case (cnt_op_s)
      CNT_INC:  cnt_nxt_s = cnt_r + CNT_W'(1);
      CNT_DEC:  cnt_nxt_s = cnt_r - CNT_W'(1);
      CNT_HOLD: cnt_nxt_s = cnt_r;
      CNT_BOTH: cnt_nxt_s = cnt_r;
      default:  cnt_nxt_s = cnt_r;
    endcase
  end

  // Busy vector and pending count state; reset clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign pend_cnt = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with same-cycle write bypass,
// optional hardwired-zero R0 and a write-pending scoreboard.
// Optional feature macro: REGFILE_SB_PARITY_EN adds per-register even parity
// (DATA_W up to 64) and the par_err output.
// NUM_REGS must be a power of two >= 2; NUM_RD is 1..4.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = RF_DEF_DATA_W,
  parameter int NUM_REGS = RF_DEF_NUM_REGS,
  parameter int NUM_RD   = RF_DEF_NUM_RD,
  parameter int R0_ZERO  = 1,
  localparam int ADDR_W  = rf_addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
`ifdef REGFILE_SB_PARITY_EN
  output logic [NUM_RD-1:0]        par_err,
`endif
  output logic [ADDR_W:0]          pend_cnt
);

  logic [DATA_W-1:0]   mem_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;
  logic                wr_ok_s;
  logic [ADDR_W-1:0]   ra_s [NUM_RD];
  logic [NUM_RD-1:0]   r0_hit_s;
  logic [NUM_RD-1:0]   byp_s;

  // A write to a hardwired-zero R0 is dropped before it reaches the array.
  always_comb begin
    if ((R0_ZERO != 0) && (wr_addr == {ADDR_W{1'b0}})) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = wr_en;
    end
  end

  // Register array; reset clears every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

`ifdef REGFILE_SB_PARITY_EN
  logic [NUM_REGS-1:0] par_r;

  // Parity bit captured from the write data alongside each array write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_r <= {NUM_REGS{1'b0}};
    end else if (wr_ok_s) begin
      par_r[wr_addr] <= rf_parity(RF_MAX_DATA_W'(wr_data));
    end
  end
`endif

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .R0_ZERO  (R0_ZERO)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy_s),
    .pend_cnt (pend_cnt)
  );

  // Per-port read: R0 forces zero, a same-cycle write bypasses the array and
  // satisfies the busy check, otherwise the array and busy bit are looked up.
  always_comb begin
    rd_data  = {(NUM_RD*DATA_W){1'b0}};
    rd_busy  = {NUM_RD{1'b0}};
    r0_hit_s = {NUM_RD{1'b0}};
    byp_s    = {NUM_RD{1'b0}};
`ifdef REGFILE_SB_PARITY_EN
    par_err  = {NUM_RD{1'b0}};
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      ra_s[k]     = rd_addr[k*ADDR_W +: ADDR_W];
      r0_hit_s[k] = (R0_ZERO != 0) && (ra_s[k] == {ADDR_W{1'b0}});
      byp_s[k]    = wr_en && (wr_addr == ra_s[k]);
      if (r0_hit_s[k]) begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[k]                  = 1'b0;
      end else if (byp_s[k]) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
        rd_busy[k]                  = 1'b0;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = mem_r[ra_s[k]];
        rd_busy[k]                  = busy_s[ra_s[k]];
`ifdef REGFILE_SB_PARITY_EN
        par_err[k] = par_r[ra_s[k]] ^ rf_parity(RF_MAX_DATA_W'(mem_r[ra_s[k]]));
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb. Three instances: the
// default build, an R0_ZERO=0 build sharing the same inputs, and a
// 16 x 32-bit, 3-read-port build. A per-instance array model predicts reads,
// busy bits and the pending count.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Inputs shared by dut (R0_ZERO=1) and dut_nz (R0_ZERO=0)
  logic        a_wr_en;
  logic [2:0]  a_wr_addr;
  logic [15:0] a_wr_data;
  logic        a_iss_en;
  logic [2:0]  a_iss_addr;
  logic [5:0]  a_rd_addr;
  logic [31:0] a_rd_data, z_rd_data;
  logic [1:0]  a_rd_busy, z_rd_busy;
  logic [3:0]  a_pend_cnt, z_pend_cnt;

  // Large configuration
  logic        b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic        b_iss_en;
  logic [3:0]  b_iss_addr;
  logic [11:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic [4:0]  b_pend_cnt;

`ifdef REGFILE_SB_PARITY_EN
  logic [1:0] a_par_err, z_par_err;
  logic [2:0] b_par_err;
`endif

  regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .R0_ZERO(1)) dut (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_busy(a_rd_busy),
`ifdef REGFILE_SB_PARITY_EN
    .par_err(a_par_err),
`endif
    .pend_cnt(a_pend_cnt));

  regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .R0_ZERO(0)) dut_nz (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_en(a_iss_en), .iss_addr(a_iss_addr), .rd_addr(a_rd_addr),
    .rd_data(z_rd_data), .rd_busy(z_rd_busy),
`ifdef REGFILE_SB_PARITY_EN
    .par_err(z_par_err),
`endif
    .pend_cnt(z_pend_cnt));

  regfile_sb #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .R0_ZERO(1)) dut_big (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy),
`ifdef REGFILE_SB_PARITY_EN
    .par_err(b_par_err),
`endif
    .pend_cnt(b_pend_cnt));

  // ---------------- reference model (0 = dut, 1 = dut_nz, 2 = dut_big) ----
  logic [31:0] m_regs [3][16];
  bit          m_busy [3][16];

  function automatic bit m_r0z(input int m);
    return (m != 1);
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 3; m++) begin
      for (int r = 0; r < 16; r++) begin
        m_regs[m][r] = 32'h0;
        m_busy[m][r] = 1'b0;
      end
    end
  endfunction

  function automatic void model_tick(input int m, input logic we, input int wa,
                                     input logic [31:0] wd, input logic ie, input int ia);
    if (we && !(m_r0z(m) && wa == 0)) m_regs[m][wa] = wd;
    if (we) m_busy[m][wa] = 1'b0;
    if (ie && !(m_r0z(m) && ia == 0)) m_busy[m][ia] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_data(input int m, input int addr, input logic we,
                                           input int wa, input logic [31:0] wd);
    if (m_r0z(m) && addr == 0) return 32'h0;
    if (we && wa == addr) return wd;
    return m_regs[m][addr];
  endfunction

  function automatic logic exp_busy(input int m, input int addr, input logic we, input int wa);
    if (m_r0z(m) && addr == 0) return 1'b0;
    if (we && wa == addr) return 1'b0;
    return m_busy[m][addr];
  endfunction

  function automatic int exp_cnt(input int m);
    int c = 0;
    for (int r = 0; r < 16; r++) c += int'(m_busy[m][r]);
    return c;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    a_wr_en = 1'b0; a_wr_addr = 3'd0; a_wr_data = 16'h0;
    a_iss_en = 1'b0; a_iss_addr = 3'd0;
    b_wr_en = 1'b0; b_wr_addr = 4'd0; b_wr_data = 32'h0;
    b_iss_en = 1'b0; b_iss_addr = 4'd0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) begin
      model_tick(0, a_wr_en, int'(a_wr_addr), {16'h0, a_wr_data}, a_iss_en, int'(a_iss_addr));
      model_tick(1, a_wr_en, int'(a_wr_addr), {16'h0, a_wr_data}, a_iss_en, int'(a_iss_addr));
      model_tick(2, b_wr_en, int'(b_wr_addr), b_wr_data, b_iss_en, int'(b_iss_addr));
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int a = 0; a < 8; a++) begin
      a_rd_addr = {3'(a), 3'(a)};
      #1;
      checks++;
      if ({a_rd_data, z_rd_data, a_rd_busy, z_rd_busy} !== 68'h0) begin
        failures++;
        $display("FAIL reset_read a=%0d: got data=%h/%h busy=%b/%b required all 0",
                 a, a_rd_data, z_rd_data, a_rd_busy, z_rd_busy);
      end
    end
    checks++;
    if ({a_pend_cnt, z_pend_cnt, b_pend_cnt} !== 13'h0) begin
      failures++;
      $display("FAIL reset_pend: got %0d/%0d/%0d required 0", a_pend_cnt, z_pend_cnt, b_pend_cnt);
    end
    cycle();
    rst = 1'b0;
    // Mid-run: write+issue r3, then an asynchronous reset pulse
    a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'h1234;
    a_iss_en = 1'b1; a_iss_addr = 3'd3;
    cycle();
    idle_inputs();
    a_rd_addr = {3'd3, 3'd3};
    #1;
    checks++;
    if (a_rd_data[15:0] !== 16'h1234 || a_rd_busy !== 2'b11 || a_pend_cnt !== 4'd1) begin
      failures++;
      $display("FAIL prereset_r3: got data=%h busy=%b pend=%0d required 1234 11 1",
               a_rd_data[15:0], a_rd_busy, a_pend_cnt);
    end
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({a_rd_data, z_rd_data, a_rd_busy, z_rd_busy, a_pend_cnt, z_pend_cnt} !== 76'h0) begin
      failures++;
      $display("FAIL async_reset: got data=%h/%h busy=%b/%b pend=%0d/%0d required all 0",
               a_rd_data, z_rd_data, a_rd_busy, z_rd_busy, a_pend_cnt, z_pend_cnt);
    end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    a_wr_en = 1'b1; a_wr_addr = 3'd5; a_wr_data = 16'hBEEF;
    a_rd_addr = {3'd1, 3'd5};
    #1;
    checks++;
    if (a_rd_data[15:0] !== 16'hBEEF || z_rd_data[15:0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_same_cycle: got %h/%h required beef", a_rd_data[15:0], z_rd_data[15:0]);
    end
    cycle();
    a_wr_en = 1'b0;
    #1;
    checks++;
    if (a_rd_data[15:0] !== 16'hBEEF || z_rd_data[15:0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL bypass_stored: got %h/%h required beef", a_rd_data[15:0], z_rd_data[15:0]);
    end
  endtask

  task automatic test_r0();
    a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 16'hFFFF;
    a_iss_en = 1'b1; a_iss_addr = 3'd0;
    a_rd_addr = {3'd0, 3'd0};
    #1;
    checks++;
    if (a_rd_data !== 32'h0 || a_rd_busy !== 2'b00 || z_rd_data !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL r0_same_cycle: got r0z=%h busy=%b nz=%h required 0 00 ffffffff",
               a_rd_data, a_rd_busy, z_rd_data);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (a_rd_data !== 32'h0 || a_rd_busy !== 2'b00 || a_pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL r0_zero: got data=%h busy=%b pend=%0d required 0 00 0",
               a_rd_data, a_rd_busy, a_pend_cnt);
    end
    checks++;
    if (z_rd_data !== 32'hFFFF_FFFF || z_rd_busy !== 2'b11 || z_pend_cnt !== 4'd1) begin
      failures++;
      $display("FAIL r0_nonzero: got data=%h busy=%b pend=%0d required ffffffff 11 1",
               z_rd_data, z_rd_busy, z_pend_cnt);
    end
    a_wr_en = 1'b1; a_wr_addr = 3'd0; a_wr_data = 16'hFFFF;
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (z_pend_cnt !== 4'd0 || z_rd_busy !== 2'b00) begin
      failures++;
      $display("FAIL r0_nonzero_clear: got pend=%0d busy=%b required 0 00", z_pend_cnt, z_rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    a_iss_en = 1'b1; a_iss_addr = 3'd2; a_rd_addr = {3'd2, 3'd2};
    #1;
    checks++;
    if (a_rd_busy !== 2'b00) begin
      failures++;
      $display("FAIL issue_not_immediate: got busy=%b required 00", a_rd_busy);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (a_rd_busy !== 2'b11 || a_pend_cnt !== 4'd1) begin
      failures++;
      $display("FAIL issue_r2: got busy=%b pend=%0d required 11 1", a_rd_busy, a_pend_cnt);
    end
    a_wr_en = 1'b1; a_wr_addr = 3'd2; a_wr_data = 16'h2222;
    #1;
    checks++;
    if (a_rd_busy !== 2'b00 || a_pend_cnt !== 4'd1 || a_rd_data[15:0] !== 16'h2222) begin
      failures++;
      $display("FAIL wb_r2_same_cycle: got busy=%b pend=%0d data=%h required 00 1 2222",
               a_rd_busy, a_pend_cnt, a_rd_data[15:0]);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (a_pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wb_r2_pend: got %0d required 0", a_pend_cnt);
    end
    a_iss_en = 1'b1; a_iss_addr = 3'd4;
    a_wr_en = 1'b1; a_wr_addr = 3'd4; a_wr_data = 16'h4444;
    cycle();
    idle_inputs();
    a_rd_addr = {3'd4, 3'd4};
    #1;
    checks++;
    if (a_rd_busy !== 2'b11 || a_pend_cnt !== 4'd1 || a_rd_data[15:0] !== 16'h4444) begin
      failures++;
      $display("FAIL iss_wb_same_r4: got busy=%b pend=%0d data=%h required 11 1 4444",
               a_rd_busy, a_pend_cnt, a_rd_data[15:0]);
    end
    a_iss_en = 1'b1; a_iss_addr = 3'd6;
    a_wr_en = 1'b1; a_wr_addr = 3'd4; a_wr_data = 16'h4545;
    cycle();
    idle_inputs();
    a_rd_addr = {3'd4, 3'd6};
    #1;
    checks++;
    if (a_rd_busy !== 2'b01 || a_pend_cnt !== 4'd1) begin
      failures++;
      $display("FAIL iss_wb_diff: got busy=%b pend=%0d required 01 1", a_rd_busy, a_pend_cnt);
    end
    a_wr_en = 1'b1; a_wr_addr = 3'd6; a_wr_data = 16'h6666;
    cycle();
    idle_inputs();
  endtask

  task automatic test_fill();
    for (int r = 1; r < 8; r++) begin
      a_iss_en = 1'b1; a_iss_addr = 3'(r);
      cycle();
      checks++;
      if (int'(a_pend_cnt) != exp_cnt(0) || int'(z_pend_cnt) != exp_cnt(1)) begin
        failures++;
        $display("FAIL fill_pend r=%0d: got %0d/%0d required %0d/%0d",
                 r, a_pend_cnt, z_pend_cnt, exp_cnt(0), exp_cnt(1));
      end
    end
    idle_inputs();
    #1;
    checks++;
    if (a_pend_cnt !== 4'd7) begin
      failures++;
      $display("FAIL fill_full: got %0d required 7", a_pend_cnt);
    end
    for (int r = 1; r < 8; r++) begin
      a_wr_en = 1'b1; a_wr_addr = 3'(r); a_wr_data = 16'(r * 16'h1111);
      cycle();
      checks++;
      if (int'(a_pend_cnt) != exp_cnt(0) || int'(z_pend_cnt) != exp_cnt(1)) begin
        failures++;
        $display("FAIL drain_pend r=%0d: got %0d/%0d required %0d/%0d",
                 r, a_pend_cnt, z_pend_cnt, exp_cnt(0), exp_cnt(1));
      end
    end
    idle_inputs();
    #1;
    checks++;
    if (a_pend_cnt !== 4'd0) begin
      failures++;
      $display("FAIL drain_empty: got %0d required 0", a_pend_cnt);
    end
  endtask

  task automatic test_parametric();
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 32'hF00D_F00D;
    cycle();
    b_wr_addr = 4'd8; b_wr_data = 32'h8888_8888;
    cycle();
    b_wr_addr = 4'd0; b_wr_data = 32'hFFFF_FFFF;
    cycle();
    idle_inputs();
    b_rd_addr = {4'd8, 4'd0, 4'd15};
    #1;
    checks++;
    if (b_rd_data !== {32'h8888_8888, 32'h0, 32'hF00D_F00D} || b_rd_busy !== 3'b000) begin
      failures++;
      $display("FAIL big_three_ports: got %h busy=%b required 88888888_00000000_f00df00d 000",
               b_rd_data, b_rd_busy);
    end
  endtask

  task automatic test_random();
    logic [31:0] ed;
    logic        eb;
    for (int c = 0; c < 10000; c++) begin
      a_wr_en = 1'($urandom_range(0, 1)); a_wr_addr = 3'($urandom); a_wr_data = 16'($urandom);
      a_iss_en = 1'($urandom_range(0, 1)); a_iss_addr = 3'($urandom); a_rd_addr = 6'($urandom);
      b_wr_en = 1'($urandom_range(0, 1)); b_wr_addr = 4'($urandom); b_wr_data = $urandom;
      b_iss_en = 1'($urandom_range(0, 1)); b_iss_addr = 4'($urandom); b_rd_addr = 12'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        ed = exp_data(0, int'(a_rd_addr[k*3 +: 3]), a_wr_en, int'(a_wr_addr), {16'h0, a_wr_data});
        eb = exp_busy(0, int'(a_rd_addr[k*3 +: 3]), a_wr_en, int'(a_wr_addr));
        checks++;
        if (a_rd_data[k*16 +: 16] !== ed[15:0] || a_rd_busy[k] !== eb) begin
          failures++;
          $display("FAIL rand_dut c=%0d port=%0d: got %h/%b required %h/%b",
                   c, k, a_rd_data[k*16 +: 16], a_rd_busy[k], ed[15:0], eb);
        end
        ed = exp_data(1, int'(a_rd_addr[k*3 +: 3]), a_wr_en, int'(a_wr_addr), {16'h0, a_wr_data});
        eb = exp_busy(1, int'(a_rd_addr[k*3 +: 3]), a_wr_en, int'(a_wr_addr));
        checks++;
        if (z_rd_data[k*16 +: 16] !== ed[15:0] || z_rd_busy[k] !== eb) begin
          failures++;
          $display("FAIL rand_nz c=%0d port=%0d: got %h/%b required %h/%b",
                   c, k, z_rd_data[k*16 +: 16], z_rd_busy[k], ed[15:0], eb);
        end
      end
      for (int k = 0; k < 3; k++) begin
        ed = exp_data(2, int'(b_rd_addr[k*4 +: 4]), b_wr_en, int'(b_wr_addr), b_wr_data);
        eb = exp_busy(2, int'(b_rd_addr[k*4 +: 4]), b_wr_en, int'(b_wr_addr));
        checks++;
        if (b_rd_data[k*32 +: 32] !== ed || b_rd_busy[k] !== eb) begin
          failures++;
          $display("FAIL rand_big c=%0d port=%0d: got %h/%b required %h/%b",
                   c, k, b_rd_data[k*32 +: 32], b_rd_busy[k], ed, eb);
        end
      end
      checks++;
      if (int'(a_pend_cnt) != exp_cnt(0) || int'(z_pend_cnt) != exp_cnt(1) ||
          int'(b_pend_cnt) != exp_cnt(2)) begin
        failures++;
        $display("FAIL rand_pend c=%0d: got %0d/%0d/%0d required %0d/%0d/%0d", c,
                 a_pend_cnt, z_pend_cnt, b_pend_cnt, exp_cnt(0), exp_cnt(1), exp_cnt(2));
      end
      cycle();
    end
    idle_inputs();
  endtask

`ifdef REGFILE_SB_PARITY_EN
  task automatic test_parity();
    a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'h00F0;
    cycle();
    idle_inputs();
    a_rd_addr = {3'd3, 3'd3};
    #1;
    checks++;
    if (a_par_err !== 2'b00) begin
      failures++;
      $display("FAIL parity_clean: got %b required 00", a_par_err);
    end
    dut.mem_r[3] = dut.mem_r[3] ^ 16'h0001;
    #1;
    checks++;
    if (a_par_err !== 2'b11) begin
      failures++;
      $display("FAIL parity_flip: got %b required 11", a_par_err);
    end
    a_wr_en = 1'b1; a_wr_addr = 3'd3; a_wr_data = 16'h0001;
    #1;
    checks++;
    if (a_par_err !== 2'b00) begin
      failures++;
      $display("FAIL parity_bypass: got %b required 00", a_par_err);
    end
    cycle();
    idle_inputs();
    #1;
    checks++;
    if (a_par_err !== 2'b00) begin
      failures++;
      $display("FAIL parity_rewrite: got %b required 00", a_par_err);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    a_rd_addr = 6'd0;
    b_rd_addr = 12'd0;
    model_clear();
    #3;
    test_reset();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_fill();
    test_parametric();
`ifdef REGFILE_SB_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
